pldata_capture_writer: RTL and testbench

// Frame capture engine feeding the PL data BRAM (PS-readable). Takes NUM_SRC sample streams
// (AD9826 pixel words, data generator, ...), or an internal test pattern, selects one per frame,
// and writes FRAME_LEN words into one of two ping-pong banks with byte addressing.

---
 rtl/pldata_capture_writer.sv | 212 +++++++++++++++++++++
 tb/tb_pldata_capture_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pldata_capture_writer.sv
// Frame capture engine: selects one sample stream or an internal pattern per frame and
// writes it into one of two ping-pong banks of the PS-readable PL data BRAM.
module pldata_capture_writer #(
  parameter  int NUM_SRC   = 2,
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 10,
  parameter  int MAX_WORDS = 128,
  // One extra select bit so that an out-of-range stream number can be presented and flagged.
  localparam int SEL_W     = $clog2(NUM_SRC) + 1,
  localparam int BE_W      = DATA_W / 8,
  localparam int LEN_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic                      abort_in,
  input  logic [SEL_W-1:0]          src_sel_in,
  input  logic [1:0]                mode_in,
  input  logic [DATA_W-1:0]         pat_val_in,
  input  logic [LEN_W-1:0]          frame_len_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]        src_valid_in,
  input  logic                      irq_ack_in,
  output logic                      ram_wr_o,
  output logic [BE_W-1:0]           ram_we_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [DATA_W-1:0]         ram_din_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      irq_o,
  output logic                      bank_o,
  output logic                      overrun_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [1:0]        MODE_STREAM = 2'd0;
  localparam logic [1:0]        MODE_INC    = 2'd1;
  localparam logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(MAX_WORDS * BE_W);
  localparam logic [LEN_W-1:0]  LEN_MAX     = LEN_W'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [1:0]          mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                wr_bank_q, wr_bank_d;
  logic                ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                irq_q, irq_d;
  logic                bank_q, bank_d;
  logic                overrun_q, overrun_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   sel_data_s;
  logic                sel_valid_s;
  logic                word_ok_s;
  logic [LEN_W-1:0]    eff_len_s;

  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data_s  = (sel_q == SEL_W'(k)) ? src_data_in[k*DATA_W +: DATA_W] : sel_data_s;
      sel_valid_s = (sel_q == SEL_W'(k)) ? src_valid_in[k] : sel_valid_s;
    end

    eff_len_s = ((frame_len_in == '0) || (frame_len_in > LEN_MAX)) ? LEN_MAX : frame_len_in;
    word_ok_s = (mode_q == MODE_STREAM) ? sel_valid_s : 1'b1;

    state_d     = state_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    next_addr_d = next_addr_q;
    wr_bank_d   = wr_bank_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    done_d      = 1'b0;
    bank_d      = bank_q;
    overrun_d   = overrun_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (src_sel_in < SEL_W'(NUM_SRC)) begin
            state_d     = ST_CAPTURE;
            sel_d       = src_sel_in;
            mode_d      = mode_in;
            len_d       = eff_len_s;
            cnt_d       = '0;
            pattern_d   = pat_val_in;
            next_addr_d = wr_bank_q ? BANK1_BASE : '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        err_d = err_q | start_in;
        // Abort outranks completion; a write registered last cycle still goes out.
        if (abort_in) begin
          state_d = ST_IDLE;
        end else if (cnt_q == len_q) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          bank_d    = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          overrun_d = overrun_q | (irq_q & ~irq_ack_in);
        end else if (word_ok_s) begin
          ram_wr_d    = 1'b1;
          ram_addr_d  = next_addr_q;
          ram_din_d   = (mode_q == MODE_STREAM) ? sel_data_s : pattern_q;
          next_addr_d = next_addr_q + ADDR_W'(BE_W);
          cnt_d       = cnt_q + LEN_W'(1);
          pattern_d   = (mode_q == MODE_INC) ? (pattern_q + DATA_W'(1)) : pattern_q;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_DONE: begin
        err_d   = err_q | start_in;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CAPTURE);

    // Completion sets the interrupt even if the PS acknowledges in the same cycle.
    if (done_d) begin
      irq_d = 1'b1;
    end else if (irq_ack_in) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      mode_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      next_addr_q <= '0;
      wr_bank_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      bank_q      <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      next_addr_q <= next_addr_d;
      wr_bank_q   <= wr_bank_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      bank_q      <= bank_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
    end
  end

  assign ram_wr_o   = ram_wr_q;
  assign ram_we_o   = {BE_W{ram_wr_q}};
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign irq_o      = irq_q;
  assign bank_o     = bank_q;
  assign overrun_o  = overrun_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pldata_capture_writer.sv
// Directed bench for pldata_capture_writer: a cycle table for the stream-mode frame plus
// hand-written sequences for pattern frames, errors, abort, overrun and mid-frame reset.
module tb_pldata_capture_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        abort_in;
  logic [1:0]  src_sel_in;
  logic [1:0]  mode_in;
  logic [31:0] pat_val_in;
  logic [7:0]  frame_len_in;
  logic [63:0] src_data_in;
  logic [1:0]  src_valid_in;
  logic        irq_ack_in;
  logic        ram_wr_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_din_o;
  logic        busy_o, done_o, irq_o, bank_o, overrun_o, err_o;

  int total = 0;
  int bad   = 0;

  pldata_capture_writer dut (
    .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
    .src_sel_in(src_sel_in), .mode_in(mode_in), .pat_val_in(pat_val_in),
    .frame_len_in(frame_len_in), .src_data_in(src_data_in), .src_valid_in(src_valid_in),
    .irq_ack_in(irq_ack_in), .ram_wr_o(ram_wr_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .busy_o(busy_o), .done_o(done_o),
    .irq_o(irq_o), .bank_o(bank_o), .overrun_o(overrun_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        ack;
    logic        e_wr;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_busy;
    logic        e_done;
    logic        e_irq;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_in = 1'b0; abort_in = 1'b0; src_sel_in = 2'd0; mode_in = 2'd0;
    pat_val_in = 32'd0; frame_len_in = 8'd0; src_data_in = 64'd0;
    src_valid_in = 2'b00; irq_ack_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"}, {63'd0, ram_wr_o}, 64'd0);
    check({tag, "_we"}, {60'd0, ram_we_o}, 64'd0);
    check({tag, "_addr"}, {54'd0, ram_addr_o}, 64'd0);
    check({tag, "_din"}, {32'd0, ram_din_o}, 64'd0);
    check({tag, "_flags"}, {58'd0, busy_o, done_o, irq_o, bank_o, overrun_o, err_o}, 64'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pattern-mode frame: checks every write, the done pulse, and that it occurs once.
  task automatic run_pattern_frame(input logic [1:0] mode, input logic [31:0] pat,
                                   input logic [7:0] len_in, input int n_exp,
                                   input logic [9:0] base, input logic exp_bank,
                                   input logic ack_last);
    start_in = 1'b1; mode_in = mode; pat_val_in = pat; frame_len_in = len_in; src_sel_in = 2'd0;
    tick();
    start_in = 1'b0;
    check("pf_busy", {63'd0, busy_o}, 64'd1);
    for (int k = 0; k < n_exp; k++) begin
      tick();
      check("pf_wr", {60'd0, ram_we_o}, 64'hF);
      check("pf_addr", {54'd0, ram_addr_o}, {54'd0, base + 10'(4 * k)});
      check("pf_din", {32'd0, ram_din_o}, {32'd0, (mode == 2'd1) ? pat + 32'(k) : pat});
    end
    irq_ack_in = ack_last;
    tick();
    irq_ack_in = 1'b0;
    check("pf_done", {62'd0, done_o, busy_o}, 64'h2);
    check("pf_bank", {63'd0, bank_o}, {63'd0, exp_bank});
    check("pf_irq", {63'd0, irq_o}, 64'd1);
    check("pf_nowr", {63'd0, ram_wr_o}, 64'd0);
    tick();
    check("pf_done_once", {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    // Stream mode, sel=1, len=4, with gaps and stray valids on stream 0.
    tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'hBAD00000, 1'b1, 32'h11110000, 1'b0, 1'b1, 10'd0,  32'h11110000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'hBAD00001, 1'b0, 32'h0,        1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h22221111, 1'b0, 1'b1, 10'd4,  32'h22221111, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'hBAD00002, 1'b1, 32'h33332222, 1'b0, 1'b1, 10'd8,  32'h33332222, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'hBAD00003, 1'b0, 32'h0,        1'b0, 1'b0, 10'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h44443333, 1'b0, 1'b1, 10'd12, 32'h44443333, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000DEAD, 1'b0, 1'b0, 10'd0,  32'h0,        1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 10'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 10'd0,  32'h0,        1'b0, 1'b0, 1'b0};

    do_reset();
    check_zero("reset");

    src_sel_in = 2'd1; mode_in = 2'd0; frame_len_in = 8'd4;
    for (int i = 0; i < 10; i++) begin
      start_in     = tbl[i].start;
      src_valid_in = {tbl[i].v1, tbl[i].v0};
      src_data_in  = {tbl[i].d1, tbl[i].d0};
      irq_ack_in   = tbl[i].ack;
      tick();
      check($sformatf("t%0d_wr", i), {63'd0, ram_wr_o}, {63'd0, tbl[i].e_wr});
      if (tbl[i].e_wr) begin
        check($sformatf("t%0d_addr", i), {54'd0, ram_addr_o}, {54'd0, tbl[i].e_addr});
        check($sformatf("t%0d_din", i), {32'd0, ram_din_o}, {32'd0, tbl[i].e_din});
      end
      check($sformatf("t%0d_ctl", i), {61'd0, busy_o, done_o, irq_o},
            {61'd0, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_irq});
      check($sformatf("t%0d_bank", i), {63'd0, bank_o}, 64'd0);
    end
    clear_inputs();

    // Two incrementing frames without acknowledge: ping-pong banks and overrun.
    do_reset();
    run_pattern_frame(2'd1, 32'h10, 8'd4, 4, 10'd0, 1'b0, 1'b0);
    check("ovr_after_first", {63'd0, overrun_o}, 64'd0);
    run_pattern_frame(2'd1, 32'h10, 8'd4, 4, 10'd512, 1'b1, 1'b0);
    check("ovr_after_second", {63'd0, overrun_o}, 64'd1);
    irq_ack_in = 1'b1;
    tick();
    irq_ack_in = 1'b0;
    check("irq_ack_clears", {63'd0, irq_o}, 64'd0);
    check("ovr_sticky", {63'd0, overrun_o}, 64'd1);

    // len=0 means a full bank; then ack coinciding with completion keeps irq set.
    do_reset();
    run_pattern_frame(2'd2, 32'hA5A5A5A5, 8'd0, 128, 10'd0, 1'b0, 1'b0);
    check("full_irq", {63'd0, irq_o}, 64'd1);
    run_pattern_frame(2'd1, 32'h0, 8'd2, 2, 10'd512, 1'b1, 1'b1);
    check("ack_same_irq", {63'd0, irq_o}, 64'd1);
    check("ack_same_no_ovr", {63'd0, overrun_o}, 64'd0);

    // Illegal select is refused and flagged.
    do_reset();
    start_in = 1'b1; src_sel_in = 2'd3; frame_len_in = 8'd4;
    tick();
    start_in = 1'b0;
    check("badsel_busy", {63'd0, busy_o}, 64'd0);
    check("badsel_err", {63'd0, err_o}, 64'd1);

    // Start while capturing is ignored; abort after two words.
    do_reset();
    start_in = 1'b1; src_sel_in = 2'd0; mode_in = 2'd0; frame_len_in = 8'd4;
    tick();
    check("ab_busy", {62'd0, busy_o, err_o}, 64'h2);
    src_valid_in = 2'b01; src_data_in = {32'h0, 32'hA0};
    tick();
    start_in = 1'b0;
    check("ab_w0", {22'd0, ram_wr_o, ram_addr_o, ram_din_o}, {22'd0, 1'b1, 10'd0, 32'hA0});
    check("ab_err", {62'd0, busy_o, err_o}, 64'h3);
    src_data_in = {32'h0, 32'hA1};
    tick();
    check("ab_w1", {22'd0, ram_wr_o, ram_addr_o, ram_din_o}, {22'd0, 1'b1, 10'd4, 32'hA1});
    abort_in = 1'b1; src_data_in = {32'h0, 32'hA2};
    tick();
    abort_in = 1'b0; src_valid_in = 2'b00;
    check("ab_idle", {60'd0, ram_wr_o, busy_o, done_o, irq_o}, 64'd0);
    tick();
    check("ab_nodone", {62'd0, done_o, irq_o}, 64'd0);
    run_pattern_frame(2'd1, 32'h50, 8'd2, 2, 10'd0, 1'b0, 1'b0);
    check("ab_err_sticky", {63'd0, err_o}, 64'd1);

    // Abort in the cycle of the last write wins over completion.
    start_in = 1'b1; mode_in = 2'd2; pat_val_in = 32'h7; frame_len_in = 8'd1;
    tick();
    start_in = 1'b0;
    tick();
    check("al_w", {22'd0, ram_wr_o, ram_addr_o, ram_din_o}, {22'd0, 1'b1, 10'd512, 32'h7});
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("al_nodone", {61'd0, busy_o, done_o, ram_wr_o}, 64'd0);
    tick();
    check("al_nodone2", {63'd0, done_o}, 64'd0);
    run_pattern_frame(2'd2, 32'h9, 8'd1, 1, 10'd512, 1'b1, 1'b0);

    // Reset mid-frame returns everything, including sticky flags, to zero.
    start_in = 1'b1; mode_in = 2'd1; pat_val_in = 32'h3; frame_len_in = 8'd10;
    tick();
    start_in = 1'b0;
    tick();
    tick();
    check("mid_wr", {63'd0, ram_wr_o}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrst");
    tick();
    check("midrst_idle", {62'd0, busy_o, ram_wr_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
